rotary_encoder_ctrl: RTL

- Front-panel rotary-encoder front end.
- Synchronises and debounces the quadrature A/B lines and the push switch, decodes direction, and accumulates signed detent clicks plus a sticky press flag.
- Output is the 8-bit register the SPI register file returns at ROTARY_ENCODER (0x19).
- Clears on that register's read strobe.
- Drives one bit of the interrupt_input vector.

---
 rtl/rotary_encoder_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rotary_encoder_ctrl.sv
// Rotary-encoder front end: sync + debounce A/B/SW, quadrature decode,
// saturating signed click count with sticky press flag, clear-on-read.
module rotary_encoder_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned STEPS_PER_CLICK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw,
    input  logic       rotary_encoder_rd_stb,
    output logic [7:0] rotary_encoder_reg,
    output logic       enc_irq,
    output logic       enc_err_stb
);

    typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_ILLEGAL} step_t;

    localparam logic [15:0]       DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] SUB_MAX = 4'(STEPS_PER_CLICK);
    localparam logic signed [3:0] SUB_MIN = -SUB_MAX;

    // Bit index: 0 = A, 1 = B, 2 = SW
    logic [2:0]  sync1, sync2, deb;
    logic [15:0] db_cnt [3];

    logic [1:0]        cur_s, prev_s;
    logic              prev_sw;
    logic signed [3:0] sub_cnt, sub_next;
    step_t             step;
    logic              click_up, click_dn, press_edge, flag_next;
    logic [6:0]        cnt_base, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {enc_sw, enc_b, enc_a};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign cur_s = {deb[0], deb[1]};

    function automatic logic [1:0] cw_next(input logic [1:0] s);
        case (s)
            2'b00:   cw_next = 2'b10;
            2'b10:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b01;
            default: cw_next = 2'b00;
        endcase
    endfunction

    always_comb begin
        step = STEP_NONE;
        if (cur_s != prev_s) begin
            if (cur_s == cw_next(prev_s))      step = STEP_CW;
            else if (prev_s == cw_next(cur_s)) step = STEP_CCW;
            else                               step = STEP_ILLEGAL;
        end
    end

    always_comb begin
        sub_next = sub_cnt;
        click_up = 1'b0;
        click_dn = 1'b0;
        case (step)
            STEP_CW:      sub_next = sub_cnt + 4'sd1;
            STEP_CCW:     sub_next = sub_cnt - 4'sd1;
            STEP_ILLEGAL: sub_next = '0;
            default:      ;
        endcase
        if (step == STEP_CW && sub_next == SUB_MAX) begin
            click_up = 1'b1;
            sub_next = '0;
        end
        if (step == STEP_CCW && sub_next == SUB_MIN) begin
            click_dn = 1'b1;
            sub_next = '0;
        end
    end

    // A read clears first, then any event on the same edge lands in the cleared value
    always_comb begin
        cnt_base = rotary_encoder_rd_stb ? '0 : rotary_encoder_reg[6:0];
        cnt_next = cnt_base;
        if (click_up && cnt_base != 7'h3F)      cnt_next = cnt_base + 7'd1;
        else if (click_dn && cnt_base != 7'h40) cnt_next = cnt_base - 7'd1;
        press_edge = prev_sw & ~deb[2];
        flag_next  = (~rotary_encoder_rd_stb & rotary_encoder_reg[7]) | press_edge;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_s             <= 2'b11;
            prev_sw            <= 1'b1;
            sub_cnt            <= '0;
            rotary_encoder_reg <= '0;
            enc_err_stb        <= 1'b0;
        end else begin
            prev_s             <= cur_s;
            prev_sw            <= deb[2];
            sub_cnt            <= sub_next;
            rotary_encoder_reg <= {flag_next, cnt_next};
            enc_err_stb        <= (step == STEP_ILLEGAL);
        end
    end

    assign enc_irq = |rotary_encoder_reg;

endmodule
